microsequencer: RTL
===================

// Module: microsequencer
// PURPOSE
//  Generates the 7-bit microstore index that drives microstore_rom each cycle; the ROM's control word feeds back the next-address fields.
//  Holds the micro-PC, an incrementer, a small return stack for micro-subroutines and the decode/IRQ dispatch.
//  Sits in the control unit between the instruction encoder/condition tester and the ROM.
// PARAMETERS
//  AW         7      microaddress width (ROM index width)
//  RESET_ADDR 7'h00  address loaded on reset and by N=RST (fetch entry)
//  IRQ_ADDR   7'h5C  dispatch target when irq is pending at decode
//  STK_DEPTH  4      return-stack entries (power of 2, >=2)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-high reset
//  hold       in   1   freeze micro-PC and stack this cycle
//  mw_n       in   3   next-address select field of current control word
//  mw_s       in   2   condition-select field
//  mw_inv     in   1   invert selected condition
//  mw_cr      in   AW  branch/call target field
//  enc_addr   in   AW  decode target from instruction encoder
//  cond_in    in   4   [0]=cond tester true,[1]=moc,[2]=1'b1 const,[3]=ir bit 24
//  irq        in   1   interrupt request, sampled only on N=DEC
//  state      out  AW  registered ROM index
//  stk_err    out  1   sticky: push on full or pop on empty
// BEHAVIOUR
//  - One clock, one reset; all state updates on rising clk. Reset is synchronous, active-high:
//    state=RESET_ADDR, stack pointer=0 (empty), stk_err=0; reset wins over hold and every N code.
//  - ROM is combinational: control word for `state` is valid same cycle; next state registered at
//    next edge. Latency from mw_* change to state update = 1 clock.
//  - inc = state+1 mod 2^AW (7'h7F wraps to 7'h00). t = cond_in[mw_s] ^ mw_inv.
//  - N encodings (next state):
//    000 INC : inc
//    001 DEC : irq ? IRQ_ADDR : enc_addr
//    010 JMP : mw_cr
//    011 CJP : t ? mw_cr : inc
//    100 WAIT: t ? inc : state (typ. mw_s=1 moc; hold in place until memory completes)
//    101 CALL: push inc, go mw_cr; if stack full: no push, stk_err<=1, still go mw_cr
//    110 RET : pop -> top; if empty: go RESET_ADDR, stk_err<=1, sp unchanged
//    111 RST : RESET_ADDR, stack emptied (sp=0); stk_err unchanged
//  - hold=1: state, stack, stk_err all unchanged regardless of N (WAIT semantics not applied).
//  - stk_err clears only on reset.
//  - Stack is LIFO; sp counts 0..STK_DEPTH; full when sp==STK_DEPTH. One op per cycle max.
//  - irq is level-sampled, not latched; dropping it before a DEC cycle means normal decode.
//  - Unknown/X on mw_n is not handled; ROM always drives defined words.
// STRUCTURE
//  - microseq_pkg: N-code localparams (N_INC..N_RST), cond-select indices (CS_COND,CS_MOC,CS_TRUE,CS_IR24),
//    AW default. Shared with the ROM field-extract wrapper.
//  - Sub-module useq_stack (params AW, STK_DEPTH; ports clk, reset, push, pop, clear, din, dout,
//    full, empty). Sequencer owns next-address mux, micro-PC register and stk_err.
// TESTING
//  1 reset=1 for 2 cycles with mw_n=010,mw_cr=7'h20 -> state=7'h00, stk_err=0; release -> 7'h20 next edge.
//  2 state=7'h7F, mw_n=000 -> state=7'h00 (wrap); mw_n=011,mw_s=2,mw_inv=1 -> inc (false branch taken as inc).
//  3 state=7'h01, mw_n=100,mw_s=1: moc=0 for 3 cycles -> state stays 7'h01; moc=1 -> 7'h02 next edge;
//    repeat with hold=1,moc=1 -> stays 7'h01.
//  4 mw_n=001, enc_addr=7'h29: irq=0 -> 7'h29; irq=1 -> 7'h5C.
//  5 CALL 7'h40 from 7'h10,7'h11 (nested, STK_DEPTH=4) then RET,RET -> 7'h12 then 7'h11; 5th CALL on full
//    -> jumps, stk_err=1, stack contents intact.
//  6 RET with empty stack -> state=7'h00, stk_err=1; then N=RST -> sp=0, stk_err still 1 until reset.

Source files
------------

// File: rtl/microseq_pkg.sv
// Shared definitions for the microsequencer and the ROM field-extract wrapper.
// Contents: next-address select codes, condition-select indices, default address width.
// No logic; constants only.
package microseq_pkg;

   localparam int AW_DEF = 7;

   // Next-address select (N field of the control word)
   localparam logic [2:0] N_INC  = 3'b000;
   localparam logic [2:0] N_DEC  = 3'b001;
   localparam logic [2:0] N_JMP  = 3'b010;
   localparam logic [2:0] N_CJP  = 3'b011;
   localparam logic [2:0] N_WAIT = 3'b100;
   localparam logic [2:0] N_CALL = 3'b101;
   localparam logic [2:0] N_RET  = 3'b110;
   localparam logic [2:0] N_RST  = 3'b111;

   // Condition-select indices into cond_in
   localparam logic [1:0] CS_COND = 2'd0;
   localparam logic [1:0] CS_MOC  = 2'd1;
   localparam logic [1:0] CS_TRUE = 2'd2;
   localparam logic [1:0] CS_IR24 = 2'd3;

endpackage

// File: rtl/useq_stack.sv
// Micro-subroutine return stack (LIFO, STK_DEPTH entries of AW bits).
// Ports: push/pop/clear commands, din pushed value, dout current top, full/empty flags.
// Latency: push/pop take effect at next edge; dout is combinational from the top entry.
// Caller must not push when full nor pop when empty; clear wins over push/pop.
module useq_stack #(
   parameter int AW        = 7,
   parameter int STK_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          clear,
   input  logic [AW-1:0] din,
   output logic [AW-1:0] dout,
   output logic          full,
   output logic          empty
);
   import microseq_pkg::*;

   localparam int IW  = $clog2(STK_DEPTH);
   localparam int SPW = IW + 1;

   logic [AW-1:0]  r_mem [STK_DEPTH];
   logic [SPW-1:0] r_sp;
   logic [IW-1:0]  w_top_idx;

   // sp counts 0..STK_DEPTH; its low bits minus one address the top entry
   // (at sp==STK_DEPTH the low bits are zero and wrap to the last slot).
   assign w_top_idx = r_sp[IW-1:0] - IW'(1);
   assign dout      = r_mem[w_top_idx];
   assign full      = (r_sp == SPW'(STK_DEPTH));
   assign empty     = (r_sp == '0);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_sp <= '0;
      end else if (push && !full) begin
         r_sp <= r_sp + SPW'(1);
      end else if (pop && !empty) begin
         r_sp <= r_sp - SPW'(1);
      end
   end

   // Storage is not reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (!reset && !clear && push && !full) begin
         r_mem[r_sp[IW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/microsequencer.sv
// Microsequencer: micro-PC, incrementer, return stack and decode/IRQ dispatch for the microstore ROM.
// Ports: hold freezes all state; mw_* are the current control word fields; state is the registered ROM index.
// Latency 1 clock from mw_* to state; hold is the only stall, stk_err is sticky until reset.
module microsequencer #(
   parameter int            AW         = 7,
   parameter logic [AW-1:0] RESET_ADDR = 7'h00,
   parameter logic [AW-1:0] IRQ_ADDR   = 7'h5C,
   parameter int            STK_DEPTH  = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          hold,
   input  logic [2:0]    mw_n,
   input  logic [1:0]    mw_s,
   input  logic          mw_inv,
   input  logic [AW-1:0] mw_cr,
   input  logic [AW-1:0] enc_addr,
   input  logic [3:0]    cond_in,
   input  logic          irq,
   output logic [AW-1:0] state,
   output logic          stk_err
);
   import microseq_pkg::*;

   logic [AW-1:0] r_state;
   logic          r_stk_err;

   logic [AW-1:0] w_inc;
   logic          w_t;
   logic [AW-1:0] w_next;
   logic          w_err_set;
   logic          w_push;
   logic          w_pop;
   logic          w_clear;
   logic [AW-1:0] w_top;
   logic          w_full;
   logic          w_empty;

   assign w_inc = r_state + AW'(1);
   assign w_t   = cond_in[mw_s] ^ mw_inv;

   always_comb begin
      w_next    = w_inc;
      w_err_set = 1'b0;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      w_clear   = 1'b0;
      case (mw_n)
         N_INC:  w_next = w_inc;
         N_DEC:  w_next = irq ? IRQ_ADDR : enc_addr;
         N_JMP:  w_next = mw_cr;
         N_CJP:  w_next = w_t ? mw_cr : w_inc;
         N_WAIT: w_next = w_t ? w_inc : r_state;
         N_CALL: begin
            w_next    = mw_cr;
            w_push    = !w_full;
            w_err_set = w_full;
         end
         N_RET: begin
            // Underflow restarts at the fetch entry rather than using a stale entry.
            w_next    = w_empty ? RESET_ADDR : w_top;
            w_pop     = !w_empty;
            w_err_set = w_empty;
         end
         N_RST: begin
            w_next  = RESET_ADDR;
            w_clear = 1'b1;
         end
         default: w_next = w_inc;
      endcase
   end

   useq_stack #(
      .AW        (AW),
      .STK_DEPTH (STK_DEPTH)
   ) u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (w_push  && !hold),
      .pop   (w_pop   && !hold),
      .clear (w_clear && !hold),
      .din   (w_inc),
      .dout  (w_top),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= RESET_ADDR;
         r_stk_err <= 1'b0;
      end else if (!hold) begin
         r_state <= w_next;
         if (w_err_set) begin
            r_stk_err <= 1'b1;
         end
      end
   end

   assign state   = r_state;
   assign stk_err = r_stk_err;

endmodule
